// File: rtl/fse_slicer_lock.sv
// fse_slicer_lock: baud-rate QPSK slicer with decision error, windowed
// error energy and a hysteretic lock detector.
module fse_slicer_lock #(
  parameter int NBT_IN     = 12,
  parameter int NBF_IN     = 9,
  parameter int LOG2_WIN   = 6,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int NBT_ENG    = 2*(NBT_IN+1)+1+LOG2_WIN,
  parameter int ERR_TH     = 1677722
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_en_rx,
  input  logic [NBT_IN-1:0]   i_data_I,
  input  logic [NBT_IN-1:0]   i_data_Q,
  input  logic                i_valid,
  output logic                o_dec_I,
  output logic                o_dec_Q,
  output logic [NBT_IN:0]     o_err_I,
  output logic [NBT_IN:0]     o_err_Q,
  output logic                o_dec_valid,
  output logic [NBT_ENG-1:0]  o_err_energy,
  output logic                o_win_valid,
  output logic                o_lock
);

  localparam int NBE = NBT_IN + 1;                 // error width
  localparam int NBP = 2*NBE + 1;                  // squared-error width
  localparam int CW  = $clog2(((LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT) + 1);
  localparam logic signed [NBE-1:0]   ONE    = NBE'(2**NBF_IN);
  localparam logic [NBT_ENG-1:0]      TH     = NBT_ENG'(ERR_TH);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  // Receiver disable behaves exactly like reset.
  logic clr;
  assign clr = i_reset | ~i_en_rx;

  // Error against the nearest QPSK point; zero slices to +1.
  function automatic logic signed [NBE-1:0] slice_err(input logic signed [NBT_IN-1:0] y);
    logic signed [NBE-1:0] ye;
    ye = NBE'(y);
    return y[NBT_IN-1] ? (ye + ONE) : (ye - ONE);
  endfunction

  // Stage 1: register decisions and errors at each symbol strobe.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      o_dec_I     <= 1'b0;
      o_dec_Q     <= 1'b0;
      o_err_I     <= '0;
      o_err_Q     <= '0;
      o_dec_valid <= 1'b0;
    end else begin
      o_dec_valid <= i_valid;
      if (i_valid) begin
        o_dec_I <= i_data_I[NBT_IN-1];
        o_dec_Q <= i_data_Q[NBT_IN-1];
        o_err_I <= slice_err(i_data_I);
        o_err_Q <= slice_err(i_data_Q);
      end
    end
  end

  // Squared error magnitude; the sum of two squares always fits NBP bits.
  logic signed [2*NBE-1:0] sq_i, sq_q;
  logic [NBP-1:0]          p_next, p;
  logic                    p_valid;
  assign sq_i   = $signed(o_err_I) * $signed(o_err_I);
  assign sq_q   = $signed(o_err_Q) * $signed(o_err_Q);
  assign p_next = NBP'($unsigned(sq_i)) + NBP'($unsigned(sq_q));

  // Stage 2: register per-symbol error energy.
  always_ff @(posedge clk) begin
    if (clr) begin
      p       <= '0;
      p_valid <= 1'b0;
    end else begin
      p_valid <= o_dec_valid;
      if (o_dec_valid) p <= p_next;
    end
  end

  logic [NBT_ENG-1:0]  acc, acc_next;
  logic [LOG2_WIN-1:0] sym_cnt;
  assign acc_next = acc + NBT_ENG'(p);

  // Stage 3: accumulate a window; the last symbol's sum goes straight out.
  always_ff @(posedge clk) begin
    if (clr) begin
      acc          <= '0;
      sym_cnt      <= '0;
      o_err_energy <= '0;
      o_win_valid  <= 1'b0;
    end else begin
      o_win_valid <= p_valid && (sym_cnt == '1);
      if (p_valid) begin
        sym_cnt <= sym_cnt + LOG2_WIN'(1);
        if (sym_cnt == '1) begin
          o_err_energy <= acc_next;
          acc          <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

  state_t         state, state_next;
  logic [CW-1:0]  good_cnt, good_next, bad_cnt, bad_next;
  logic           good;
  assign good = (o_err_energy < TH);

  // Lock FSM state and hysteresis counters.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= UNLOCKED;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      bad_cnt  <= bad_next;
    end
  end

  // Lock FSM next state, evaluated once per completed window.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    bad_next   = bad_cnt;
    if (o_win_valid) begin
      case (state)
        UNLOCKED: begin
          if (!good) begin
            good_next = '0;
          end else if (good_cnt == CW'(LOCK_CNT - 1)) begin
            state_next = LOCKED;
            good_next  = '0;
            bad_next   = '0;
          end else begin
            good_next = good_cnt + CW'(1);
          end
        end
        LOCKED: begin
          if (good) begin
            bad_next = '0;
          end else if (bad_cnt == CW'(UNLOCK_CNT - 1)) begin
            state_next = UNLOCKED;
            good_next  = '0;
            bad_next   = '0;
          end else begin
            bad_next = bad_cnt + CW'(1);
          end
        end
        default: state_next = UNLOCKED;
      endcase
    end
  end

  assign o_lock = (state == LOCKED);

endmodule
